// File: rtl/countdown_timer8.sv
// countdown_timer8: loadable down-counter with a built-in rate divider.
//
// A preset value is counted down to zero, one step every DIV clocks while
// running. The step that takes Q from 1 to 0 raises DONE for exactly one cycle.
// Q feeds the two-digit hex display path. DONE drives an LED or the next
// control stage.
//
// Parameters:
//   WIDTH - width of Q and LOAD_VALUE
//   DIV   - CLOCK cycles per count step (>= 1)
//   DIV_W - prescaler width, 2**DIV_W >= DIV
//
// Ports:
//   CLOCK      in   system clock, rising edge
//   CLEAR      in   asynchronous active-high reset
//   LOAD       in   synchronous load strobe (highest priority)
//   LOAD_VALUE in   preset captured on LOAD
//   START      in   start / resume request (level)
//   STOP       in   pause request (level, wins over START)
//   Q          out  current count, registered
//   RUNNING    out  high while in the run state, registered
//   DONE       out  one-cycle terminal pulse, registered
//   ZERO       out  combinational Q == 0
//
// Optional build macro COUNTDOWN_TIMER8_AUTO_RELOAD_EN: the terminal step
// reloads Q from the last loaded value and keeps running, giving a periodic
// DONE. When the macro is undefined, the terminal step parks the counter at
// zero in the idle state.
module countdown_timer8 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 50000000,
    parameter int unsigned DIV_W = 26
) (
    input  logic             CLOCK,
    input  logic             CLEAR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VALUE,
    input  logic             START,
    input  logic             STOP,
    output logic [WIDTH-1:0] Q,
    output logic             RUNNING,
    output logic             DONE,
    output logic             ZERO
);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    localparam logic [DIV_W-1:0] PcLast = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] PcOne  = DIV_W'(1);
    localparam logic [WIDTH-1:0] QOne   = WIDTH'(1);

    state_e           state_q;
    logic [DIV_W-1:0] pc_q;
    logic [WIDTH-1:0] q_q;
    logic             done_q;
    logic             running_q;

    logic             tick;
    logic             go;

    assign tick = (pc_q == PcLast);
    // STOP dominates START, so a resume needs START alone.
    assign go   = START & ~STOP;

`ifdef COUNTDOWN_TIMER8_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;

    always_ff @(posedge CLOCK or posedge CLEAR) begin
        if (CLEAR) begin
            reload_q <= '0;
        end else if (LOAD) begin
            reload_q <= LOAD_VALUE;
        end
    end
`endif

    always_ff @(posedge CLOCK or posedge CLEAR) begin
        if (CLEAR) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            q_q       <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (LOAD) begin
                q_q       <= LOAD_VALUE;
                pc_q      <= '0;
                state_q   <= StIdle;
                running_q <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        // Starting from zero would underflow; ignore it.
                        if (go && (q_q != '0)) begin
                            state_q   <= StRun;
                            running_q <= 1'b1;
                            pc_q      <= '0;
                        end
                    end
                    StRun: begin
                        if (STOP) begin
                            // Hold PC and Q; a tick due this cycle is dropped.
                            state_q   <= StPause;
                            running_q <= 1'b0;
                        end else if (!tick) begin
                            pc_q <= pc_q + PcOne;
                        end else begin
                            pc_q <= '0;
                            if (q_q > QOne) begin
                                q_q <= q_q - QOne;
                            end else begin
                                done_q <= 1'b1;
`ifdef COUNTDOWN_TIMER8_AUTO_RELOAD_EN
                                q_q <= reload_q;
`else
                                q_q       <= '0;
                                state_q   <= StIdle;
                                running_q <= 1'b0;
`endif
                            end
                        end
                    end
                    StPause: begin
                        // PC was held, so the resumed period is not restarted.
                        if (go) begin
                            state_q   <= StRun;
                            running_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= StIdle;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Q       = q_q;
    assign RUNNING = running_q;
    assign DONE    = done_q;
    assign ZERO    = (q_q == '0);

endmodule

// File: tb/tb_countdown_timer8.sv
// Self-checking bench for countdown_timer8.
// Two instances share the same stimulus: DIV=4 and DIV=1. Each instance is
// compared every cycle against a behavioural model. Hand-computed vector
// tables and hand-written sequences cover the multi-cycle corner cases.
module tb_countdown_timer8;

    localparam int Width = 8;
`ifdef COUNTDOWN_TIMER8_AUTO_RELOAD_EN
    localparam bit AutoReload = 1'b1;
`else
    localparam bit AutoReload = 1'b0;
`endif

    logic             CLOCK;
    logic             CLEAR;
    logic             LOAD;
    logic [Width-1:0] LOAD_VALUE;
    logic             START;
    logic             STOP;

    logic [Width-1:0] q4, q1;
    logic             run4, run1, done4, done1, zero4, zero1;

    countdown_timer8 #(.WIDTH(Width), .DIV(4), .DIV_W(3)) dut4 (
        .CLOCK      (CLOCK),
        .CLEAR      (CLEAR),
        .LOAD       (LOAD),
        .LOAD_VALUE (LOAD_VALUE),
        .START      (START),
        .STOP       (STOP),
        .Q          (q4),
        .RUNNING    (run4),
        .DONE       (done4),
        .ZERO       (zero4)
    );

    countdown_timer8 #(.WIDTH(Width), .DIV(1), .DIV_W(1)) dut1 (
        .CLOCK      (CLOCK),
        .CLEAR      (CLEAR),
        .LOAD       (LOAD),
        .LOAD_VALUE (LOAD_VALUE),
        .START      (START),
        .STOP       (STOP),
        .Q          (q1),
        .RUNNING    (run1),
        .DONE       (done1),
        .ZERO       (zero1)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: mode, count and number of run cycles since the last step.
    localparam int MIdle = 0, MRun = 1, MPause = 2;
    int divs[2] = '{4, 1};
    int m_mode[2], m_q[2], m_elapsed[2], m_done[2], m_rel[2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = MIdle; m_q[d] = 0; m_elapsed[d] = 0; m_done[d] = 0; m_rel[d] = 0;
        end
    endfunction

    function automatic void model_step();
        for (int d = 0; d < 2; d++) begin
            m_done[d] = 0;
            if (LOAD) begin
                m_q[d] = int'(LOAD_VALUE); m_elapsed[d] = 0; m_mode[d] = MIdle;
                m_rel[d] = int'(LOAD_VALUE);
            end else if (m_mode[d] == MIdle) begin
                if (START && !STOP && m_q[d] != 0) begin
                    m_mode[d] = MRun; m_elapsed[d] = 0;
                end
            end else if (m_mode[d] == MRun) begin
                if (STOP) m_mode[d] = MPause;
                else begin
                    m_elapsed[d]++;
                    if (m_elapsed[d] == divs[d]) begin
                        m_elapsed[d] = 0;
                        if (m_q[d] > 1) m_q[d]--;
                        else begin
                            m_done[d] = 1;
                            if (AutoReload) m_q[d] = m_rel[d];
                            else begin m_q[d] = 0; m_mode[d] = MIdle; end
                        end
                    end
                end
            end else if (START && !STOP) begin
                m_mode[d] = MRun;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_q4"},    int'(q4),    m_q[0]);
        chk({tag, "_run4"},  int'(run4),  int'(m_mode[0] == MRun));
        chk({tag, "_done4"}, int'(done4), m_done[0]);
        chk({tag, "_zero4"}, int'(zero4), int'(m_q[0] == 0));
        chk({tag, "_q1"},    int'(q1),    m_q[1]);
        chk({tag, "_run1"},  int'(run1),  int'(m_mode[1] == MRun));
        chk({tag, "_done1"}, int'(done1), m_done[1]);
        chk({tag, "_zero1"}, int'(zero1), int'(m_q[1] == 0));
    endtask

    // Called at posedge+1; drives inputs, takes one edge, checks at posedge+1.
    task automatic step(input logic ld, input logic [Width-1:0] lv, input logic st,
                        input logic sp);
        LOAD = ld; LOAD_VALUE = lv; START = st; STOP = sp;
        @(posedge CLOCK);
        model_step();
        #1;
        check_all("step");
    endtask

    // Asynchronous CLEAR pulse between edges; outputs must react before the next edge.
    task automatic do_clear();
        #2 CLEAR = 1'b1;
        #1;
        model_reset();
        check_all("clear");
        #1 CLEAR = 1'b0;
    endtask

    typedef struct {
        logic             ld;
        logic [Width-1:0] lv;
        logic             st;
        logic             sp;
        logic [Width-1:0] q;
        logic             run;
        logic             done;
        logic             zero;
    } vec_t;

    vec_t tbl[15];
    int   runs;
    int   k;
    bit   seen;

    initial begin
        // Basic countdown of 3 on the DIV=4 instance.
        tbl[0] = '{1'b1, 8'd3, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0};
        for (int i = 2; i <= 12; i++) begin
            tbl[i] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'(3 - (i - 1) / 4), 1'b1, 1'b0, 1'b0};
        end
        if (AutoReload) begin
            tbl[13] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0};
            tbl[14] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0};
        end else begin
            tbl[13] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
            tbl[14] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        end

        CLEAR = 1'b1; LOAD = 1'b0; LOAD_VALUE = '0; START = 1'b0; STOP = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1;
        model_reset();
        chk("reset_q", int'(q4), 0);
        chk("reset_running", int'(run4), 0);
        chk("reset_done", int'(done4), 0);
        chk("reset_zero", int'(zero4), 1);
        check_all("reset");
        #3 CLEAR = 1'b0;

        // Table: load 3, start, count to done.
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].sp);
            chk($sformatf("tbl%0d_q", i),    int'(q4),    int'(tbl[i].q));
            chk($sformatf("tbl%0d_run", i),  int'(run4),  int'(tbl[i].run));
            chk($sformatf("tbl%0d_done", i), int'(done4), int'(tbl[i].done));
            chk($sformatf("tbl%0d_zero", i), int'(zero4), int'(tbl[i].zero));
        end

        // Pause and resume: no tick lost or duplicated.
        do_clear();
        step(1'b1, 8'd5, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        runs = 0;
        repeat (6) begin
            if (run4) runs++;
            step(1'b0, 8'd0, 1'b0, 1'b0);
        end
        chk("pause_q_before", int'(q4), 4);
        repeat (10) begin
            step(1'b0, 8'd0, 1'b0, 1'b1);
            chk("pause_q_frozen", int'(q4), 4);
        end
        chk("pause_running", int'(run4), 0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        chk("resume_running", int'(run4), 1);
        if (run4) runs++;
        step(1'b0, 8'd0, 1'b0, 1'b0);
        chk("resume_q_1clk", int'(q4), 4);
        if (run4) runs++;
        step(1'b0, 8'd0, 1'b0, 1'b0);
        chk("resume_q_2clk", int'(q4), 3);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (run4) runs++;
            step(1'b0, 8'd0, 1'b0, 1'b0);
            if (done4) seen = 1'b1;
        end
        chk("pause_done_seen", int'(seen), 1);
        chk("pause_run_clocks", runs, 20);

        // START with Q == 0 does nothing.
        do_clear();
        repeat (3) begin
            step(1'b0, 8'd0, 1'b1, 1'b0);
            chk("zero_start_running", int'(run4), 0);
            chk("zero_start_done", int'(done4), 0);
        end

        // LOAD wins over START in the same cycle.
        do_clear();
        step(1'b1, 8'd200, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        repeat (5) step(1'b0, 8'd0, 1'b0, 1'b0);
        chk("reload_mid_running", int'(run4), 1);
        step(1'b1, 8'd7, 1'b1, 1'b0);
        chk("load_start_q", int'(q4), 7);
        chk("load_start_running", int'(run4), 0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        k = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step(1'b0, 8'd0, 1'b0, 1'b0);
            k++;
            if (done4) seen = 1'b1;
        end
        chk("load7_done_latency", k, 28);
        chk("load7_final_q", int'(q4), AutoReload ? 7 : 0);

        // DIV=1: DONE N cycles after entering RUN.
        do_clear();
        step(1'b1, 8'd3, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        k = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b0, 8'd0, 1'b0, 1'b0);
            k++;
            if (done1) seen = 1'b1;
        end
        chk("div1_done_latency", k, 3);

        // DIV=1, mid-count async CLEAR, then START+STOP stays idle.
        do_clear();
        step(1'b1, 8'd2, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        chk("div1_running_before_clear", int'(run1), 1);
        do_clear();
        chk("clear_q1", int'(q1), 0);
        chk("clear_run1", int'(run1), 0);
        repeat (3) begin
            step(1'b0, 8'd0, 1'b1, 1'b1);
            chk("startstop_run1", int'(run1), 0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_clear();
            else step($urandom_range(0, 15) == 0, 8'($urandom_range(0, 12)),
                      $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/countdown_timer8.md
Name: countdown_timer8

Overview:
- Loadable down-counter with a built-in rate divider.
- Mirrors the existing up-counting T-flip-flop counter: counts a preset value down to zero at a prescaled rate, then raises a one-cycle terminal pulse.
- Q feeds the existing two-digit hex seven-segment display path unchanged. DONE drives an LED or the next control stage.

Parameters:
- WIDTH, 8, width of count value Q and LOAD_VALUE.
- DIV, 50000000, CLOCK cycles per count step (≥1).
- DIV_W, 26, prescaler register width; must satisfy 2^DIV_W ≥ DIV.

Ports:
- CLOCK  in  1  system clock; all state changes on rising edge.
- CLEAR  in  1  reset, asynchronous, active-high.
- LOAD  in  1  synchronous load strobe.
- LOAD_VALUE  in  WIDTH  preset value captured on LOAD.
- START  in  1  start / resume request (level, sampled each cycle).
- STOP  in  1  pause request (level, sampled each cycle).
- Q  out  WIDTH  current count, registered.
- RUNNING  out  1  high while in RUN state.
- DONE  out  1  registered one-cycle terminal pulse.
- ZERO  out  1  combinational, Q == 0.

Behaviour:
- Reset (CLEAR=1, any time, async): state=IDLE, Q=0, prescaler PC=0, DONE=0, RUNNING=0, ZERO=1. The next rising CLOCK edge after CLEAR falls is the first functional edge.
- States: IDLE, RUN, PAUSE. RUNNING = (state==RUN).
- DONE defaults to 0 every cycle unless set below.
- Priority each edge: LOAD > STOP > START > tick.
- LOAD (any state): Q<=LOAD_VALUE, PC<=0, state<=IDLE, DONE<=0. START/STOP in the same cycle are ignored.
- IDLE:
  - START=1, STOP=0, Q!=0 -> RUN; PC<=0.
  - START with Q==0 -> stay IDLE, no DONE.
- RUN:
  - STOP=1 -> PAUSE. PC and Q are held; any tick due that cycle is discarded (no decrement).
  - Otherwise PC increments each cycle. Tick when PC==DIV-1; PC wraps to 0 on the tick.
  - On tick with Q>1: Q<=Q-1.
  - On tick with Q==1: Q<=0, DONE<=1, state<=IDLE. DONE and Q==0 become visible in the same cycle.
- PAUSE:
  - START=1, STOP=0 -> RUN. PC resumes from its held value; no tick is lost or duplicated.
  - STOP alone -> stay PAUSE.
- START and STOP both high: treated as STOP only. IDLE stays IDLE; PAUSE stays PAUSE; RUN goes to PAUSE.
- DIV=1: tick every RUN cycle. Q decrements every clock, and DONE arrives N cycles after entering RUN with Q=N.
- Latency: with Q=N loaded and START in cycle 0, RUN begins cycle 1 and DONE is high in cycle N*DIV.
- Q never wraps below 0. No decrement occurs outside RUN.
- Mid-count CLEAR: immediate return to reset values. A pending DONE is lost.

Optional Feature:
- Macro: COUNTDOWN_TIMER8_AUTO_RELOAD_EN.
- Defined:
  - Adds register RELOAD (WIDTH bits, reset 0), written with LOAD_VALUE on every LOAD.
  - On the terminal tick (Q==1): Q<=RELOAD, DONE<=1, state stays RUN, PC wraps to 0. Counting continues periodically.
  - ZERO is not asserted at reload.
  - STOP/LOAD still behave as above.
- Undefined: terminal tick goes to Q=0, IDLE, as specified above. No RELOAD register is synthesised.

Test Plan:
- DIV=4. CLEAR pulse, then LOAD_VALUE=3 with LOAD, then START one cycle -> Q steps 3,2,1,0 every 4 clocks; DONE high exactly 1 cycle, coincident with Q=0; RUNNING falls the same cycle; ZERO=1 afterwards.
- DIV=4, Q=5, RUN. Assert STOP for 10 cycles after 6 clocks, then START -> Q frozen at 4 during PAUSE; Q reaches 3 exactly 2 RUN clocks after resume; total RUN clocks to DONE = 20.
- Q=0 in IDLE, START -> no state change, RUNNING=0, DONE never pulses.
- RUN with Q=200. LOAD_VALUE=7 with LOAD and START in the same cycle -> Q=7, state IDLE, RUNNING=0; a later START counts 7 down to 0.
- DIV=1, Q=2, RUN. CLEAR asserted asynchronously mid-cycle -> Q=0, RUNNING=0, DONE=0 immediately, before the next edge; START+STOP together afterwards -> stays IDLE.
- With COUNTDOWN_TIMER8_AUTO_RELOAD_EN, DIV=2, LOAD_VALUE=2 -> Q sequence 2,1,2,1,...; DONE pulses every 4 clocks at each reload; ZERO stays 0 throughout.
